// File: rtl/lane_phase_scheduler.sv
// lane_phase_scheduler
//   Sequences four intersection lanes through GREEN, YELLOW and ALL_RED
//   phases. The phase timing advances only on tick cycles without hold.
//   The next lane is found with a rotating-priority search starting just
//   after the current lane. Once latched, that lane is committed.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset (lane 0 green)
//   tick         timing strobe; phase timing advances only when tick=1
//   hold         manual freeze; overrides tick
//   lane_req     per-lane vehicle present / waiting
//   green        one-hot green lamp, zero outside GREEN
//   yellow       one-hot yellow lamp, zero outside YELLOW
//   active_lane  lane owning the current phase
//   phase        00=GREEN, 01=YELLOW, 10=ALL_RED
//   switch_pulse one-cycle pulse on entry to GREEN for a new lane
module lane_phase_scheduler #(
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALL_RED_T = 1,
  parameter int CNT_W     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       hold,
  input  logic [3:0] lane_req,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [1:0] active_lane,
  output logic [1:0] phase,
  output logic       switch_pulse
);

  localparam int CW1 = CNT_W + 1;
  localparam logic [CNT_W:0] MIN_G = CW1'(MIN_GREEN);
  localparam logic [CNT_W:0] MAX_G = CW1'(MAX_GREEN);
  localparam logic [CNT_W:0] YEL_T = CW1'(YELLOW_T);
  localparam logic [CNT_W:0] AR_T  = CW1'(ALL_RED_T);

  typedef enum logic [1:0] {
    PH_GREEN   = 2'b00,
    PH_YELLOW  = 2'b01,
    PH_ALL_RED = 2'b10
  } phase_t;

  phase_t           state;
  logic [1:0]       lane;
  logic [1:0]       target;
  logic [CNT_W-1:0] cnt;
  logic             pulse;

  logic             advance;
  logic [3:0]       others;
  logic [CNT_W:0]   cnt_inc;
  logic             green_exit;

  // Saturating green dwell count: holds at MAX_GREEN so an idle lane never wraps.
  function automatic logic [CNT_W-1:0] sat_green(input logic [CNT_W:0] e);
    if (e >= MAX_G) return CNT_W'(MAX_GREEN);
    return e[CNT_W-1:0];
  endfunction

  // Rotating search: cur+1, cur+2, cur+3 (mod 4); first requesting lane wins.
  function automatic logic [1:0] pick_next(input logic [3:0] oth, input logic [1:0] cur);
    logic [1:0] cand;
    logic [1:0] sel;
    logic       found;
    sel   = cur;
    found = 1'b0;
    for (int k = 1; k < 4; k++) begin
      cand = cur + 2'(k);
      if (!found && oth[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign advance = tick & ~hold;
  assign others  = lane_req & ~(4'b0001 << lane);
  assign cnt_inc = {1'b0, cnt} + CW1'(1);

  // A lane may be preempted only when someone else is waiting.
  assign green_exit = (others != 4'b0000) &&
                      (((cnt_inc >= MIN_G) && !lane_req[lane]) || (cnt_inc >= MAX_G));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= PH_GREEN;
      lane   <= 2'd0;
      target <= 2'd0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (advance) begin
        case (state)
          PH_GREEN: begin
            if (green_exit) begin
              state  <= PH_YELLOW;
              target <= pick_next(others, lane);
              cnt    <= '0;
            end else begin
              cnt <= sat_green(cnt_inc);
            end
          end
          PH_YELLOW: begin
            if (cnt_inc == YEL_T) begin
              state <= PH_ALL_RED;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc[CNT_W-1:0];
            end
          end
          PH_ALL_RED: begin
            if (cnt_inc == AR_T) begin
              state <= PH_GREEN;
              lane  <= target;
              cnt   <= '0;
              pulse <= 1'b1;
            end else begin
              cnt <= cnt_inc[CNT_W-1:0];
            end
          end
          default: begin
            state <= PH_GREEN;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Lamp decode from registered state only.
  assign green        = (state == PH_GREEN)  ? (4'b0001 << lane) : 4'b0000;
  assign yellow       = (state == PH_YELLOW) ? (4'b0001 << lane) : 4'b0000;
  assign active_lane  = lane;
  assign phase        = state;
  assign switch_pulse = pulse;

endmodule

// File: doc/lane_phase_scheduler.md
Name: lane_phase_scheduler

Overview:
- Sequences the four intersection lanes through timed green, yellow and all-red phases.
- Chooses the next lane with a rotating-priority search over the lane sensor inputs.
- Owns the dwell timing that the next-state lane logic only approximates: minimum and maximum green, yellow length, all-red clearance.
- Sits between the lane sensor inputs and the lamp drivers.

Parameters:
MIN_GREEN, 5, ticks a lane stays green before it can be preempted when it has no vehicles.
MAX_GREEN, 20, ticks after which green is forcibly ended if another lane is waiting (must be >= MIN_GREEN).
YELLOW_T, 3, ticks of yellow (>= 1).
ALL_RED_T, 1, ticks of all-red clearance (>= 1).
CNT_W, 5, phase counter width (must hold MAX_GREEN).

Ports:
clk  in  1  system clock.
rst_n  in  1  reset, asynchronous, active-low.
tick  in  1  timing strobe; all phase timing advances only on cycles with tick=1.
hold  in  1  freezes counter and state (manual override); outputs unchanged.
lane_req  in  4  lane_req[i]=1 means lane i has a vehicle waiting/present.
green  out  4  one-hot green lamp; all zero outside GREEN.
yellow  out  4  one-hot yellow lamp for the lane leaving green; all zero outside YELLOW.
active_lane  out  2  lane currently owning the phase (green, yellow or clearing).
phase  out  2  00=GREEN, 01=YELLOW, 10=ALL_RED; 11 is never produced.
switch_pulse  out  1  one-cycle pulse on the edge that enters GREEN for a new lane.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- All state is registered: phase, active_lane, target lane, and counter cnt. Outputs are decoded from registered state only, so outputs change on the same edge as the state.
- Reset values:
  - phase=GREEN, active_lane=0, target=0, cnt=0.
  - green=0001, yellow=0000, switch_pulse=0.
- Advance condition: a cycle advances only if tick=1 and hold=0. No state or counter change occurs on any other cycle.
- hold=1 takes precedence over tick.
- others = lane_req with bit active_lane masked off.
- Next lane: search active_lane+1, +2, +3 (mod 4) in that order; the first set bit of others is the next lane. Example: active 2 searches 3, 0, 1.
- GREEN, on an advance cycle, with E = cnt+1:
  - Exit to YELLOW if others != 0 and either:
    - E >= MIN_GREEN and lane_req[active_lane]=0, or
    - E >= MAX_GREEN.
  - On exit: latch target = next lane, cnt <= 0.
  - Otherwise cnt <= min(E, MAX_GREEN). The counter saturates and does not wrap.
  - An idle intersection holds the current green indefinitely.
- YELLOW, on an advance cycle:
  - If cnt+1 == YELLOW_T: go to ALL_RED, cnt <= 0.
  - Else cnt <= cnt+1.
  - yellow = onehot(active_lane).
- ALL_RED, on an advance cycle:
  - If cnt+1 == ALL_RED_T: go to GREEN, active_lane <= target, cnt <= 0, switch_pulse=1 for that one cycle.
  - Else cnt <= cnt+1.
  - green = yellow = 0000.
- Target is committed once latched. lane_req changes during YELLOW/ALL_RED do not alter the target, even if the target stops requesting.
- Simultaneous requests are resolved by rotation order only. There is no fixed lane priority.
- Reset mid-phase returns immediately (asynchronously) to the reset state: lane 0 green, cnt=0.
- Safety invariant on every cycle:
  - green and yellow are never both nonzero.
  - Each of green and yellow is one-hot or zero.
  - switch_pulse=1 only with phase=GREEN.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle with lane_req=1111 -> outputs go to green=0001, yellow=0000, phase=00, active_lane=0 without waiting for a clock edge.
2. Min-green preemption: tick=1 every cycle, lane_req=0100 -> green=0001 for 5 cycles; then yellow=0001 for 3 cycles; then all-red for 1 cycle; then green=0100, active_lane=2, switch_pulse high for exactly 1 cycle.
3. Max-green: lane_req=0011 held, active lane 0 -> green=0001 persists through tick 19; exit on tick 20; after yellow/all-red, green=0010.
4. Idle and saturation: lane_req=0000 for 40 ticks -> green=0001 throughout and cnt stays at 20. Then lane_req=1000 -> yellow=0001 on the very next tick, because E >= MIN_GREEN.
5. Rotation wrap and committed target: active lane 2, lane_req=0011 -> target 0. Drop lane_req to 0000 during yellow -> green=0001 still follows all-red.
6. Hold and sparse tick: tick every 4th cycle with hold pulsed high for 2 ticks during yellow -> yellow lasts exactly 3 non-held ticks (20 cycles total); no state change while hold=1.
